// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg: state encoding, opcode constants and reset defaults shared by exec_ctrl
package exec_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH0,
        FETCH1,
        OPER,
        EXEC,
        STORE,
        HALT
    } state_t;

    // Opcode nibble carried in byte0[7:4]; 0xxx selects an ALU function
    localparam logic [3:0] OP_ADI = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_LSL = 4'h6;
    localparam logic [3:0] OP_LSR = 4'h7;
    localparam logic [3:0] OP_LDA = 4'h8;
    localparam logic [3:0] OP_STA = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_JC  = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [7:0] RESET_PC_DEF = 8'h00;

endpackage

// File: rtl/exec_ctrl_op_decode.sv
// op_decode: combinational classification of the opcode nibble
//   op        in   opcode, byte0[7:4]
//   needs_mem out  instruction reads a memory operand (non-ADI ALU ops, LDA)
//   is_alu    out  ALU instruction (op[3] = 0)
//   is_store  out  STA
//   is_branch out  JMP, JZ or JC
//   is_halt   out  HLT
//   func      out  ALU function, op[2:0]
module op_decode
    import exec_ctrl_pkg::*;
(
    input  logic [3:0] op,
    output logic       needs_mem,
    output logic       is_alu,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_halt,
    output logic [2:0] func
);

    assign is_alu    = !op[3];
    assign needs_mem = (is_alu && op != OP_ADI) || op == OP_LDA;
    assign is_store  = op == OP_STA;
    assign is_branch = op == OP_JMP || op == OP_JZ || op == OP_JC;
    assign is_halt   = op == OP_HLT;
    assign func      = op[2:0];

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: fetch/decode/execute sequencer driving an external 8-op ALU
//   clk_i, rst_i (async, active high), run_i (start fetching when high)
//   mem_*    byte-wide req/ack memory port; req, we, addr, wdata are registered
//            and held until the ack cycle
//   alu_*    operands/function out to the ALU, result and flags back in
//   pc_o, acc_o, fz_o, fc_o  architectural state; halted_o high in HALT
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int                WORD_W   = 8,
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [WORD_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    input  logic [WORD_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [WORD_W-1:0] alu_a_imm_o,
    output logic [WORD_W-1:0] alu_a_mem_o,
    output logic [WORD_W-1:0] alu_b_o,
    output logic [2:0]        alu_func_o,
    input  logic [WORD_W-1:0] alu_result_i,
    input  logic              alu_fz_i,
    input  logic              alu_fc_i,
    output logic [WORD_W-1:0] pc_o,
    output logic [WORD_W-1:0] acc_o,
    output logic              fz_o,
    output logic              fc_o,
    output logic              halted_o
);

    state_t            state;
    logic [3:0]        op;
    logic [WORD_W-1:0] ir1;
    logic [WORD_W-1:0] opnd;
    logic              needs_mem;
    logic              is_alu;
    logic              is_store;
    logic              is_branch;
    logic              is_halt;
    logic [2:0]        func;
    logic              ack;
    logic              take;
    logic [WORD_W-1:0] pc_inc;
    logic [WORD_W-1:0] pc_next;

    op_decode u_dec (
        .op        (op),
        .needs_mem (needs_mem),
        .is_alu    (is_alu),
        .is_store  (is_store),
        .is_branch (is_branch),
        .is_halt   (is_halt),
        .func      (func)
    );

    // Ack only counts while a request is outstanding
    assign ack     = mem_req_o && mem_ack_i;
    assign pc_inc  = pc_o + 1'b1;
    // Branch conditions use the flags registered before this instruction
    assign take    = is_branch && (op == OP_JMP || (op == OP_JZ && fz_o) || (op == OP_JC && fc_o));
    assign pc_next = take ? ir1 : pc_o;

    assign alu_a_imm_o = ir1;
    assign alu_a_mem_o = opnd;
    assign alu_b_o     = acc_o;
    assign alu_func_o  = func;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= FETCH0;
            pc_o        <= RESET_PC;
            acc_o       <= '0;
            fz_o        <= 1'b0;
            fc_o        <= 1'b0;
            op          <= '0;
            ir1         <= '0;
            opnd        <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            halted_o    <= 1'b0;
        end else begin
            case (state)
                FETCH0: begin
                    if (ack) begin
                        op         <= mem_rdata_i[7:4];
                        pc_o       <= pc_inc;
                        mem_addr_o <= pc_inc;
                        state      <= FETCH1;
                    end else if (!mem_req_o) begin
                        // run_i only gates the start of a fetch, never an issued one
                        mem_req_o  <= run_i;
                        mem_addr_o <= pc_o;
                    end
                end
                FETCH1: begin
                    if (ack) begin
                        ir1         <= mem_rdata_i;
                        pc_o        <= pc_inc;
                        mem_addr_o  <= mem_rdata_i;
                        mem_we_o    <= is_store;
                        mem_wdata_o <= acc_o;
                        mem_req_o   <= needs_mem || is_store;
                        halted_o    <= is_halt;
                        state       <= is_halt ? HALT : is_store ? STORE : needs_mem ? OPER : EXEC;
                    end
                end
                OPER: begin
                    if (ack) begin
                        opnd      <= mem_rdata_i;
                        mem_req_o <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_alu) begin
                        acc_o <= alu_result_i;
                        fz_o  <= alu_fz_i;
                        fc_o  <= alu_fc_i;
                    end else if (op == OP_LDA) begin
                        acc_o <= opnd;
                        fz_o  <= opnd == '0;
                    end
                    pc_o       <= pc_next;
                    mem_addr_o <= pc_next;
                    mem_req_o  <= run_i;
                    state      <= FETCH0;
                end
                STORE: begin
                    // Return through an idle FETCH0 cycle so STA takes four cycles
                    if (ack) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        state     <= FETCH0;
                    end
                end
                HALT: begin
                    halted_o <= 1'b1;
                end
                default: state <= FETCH0;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: scoreboard bench for exec_ctrl with a behavioural memory and ALU
module tb_exec_ctrl;
    import exec_ctrl_pkg::*;

    typedef struct packed {
        logic [7:0] gap;
        logic [3:0] we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] acc;
        logic [3:0] fz;
        logic [3:0] fc;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       mem_req, mem_we, mem_ack;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] alu_a_imm, alu_a_mem, alu_b, alu_res;
    logic [2:0] alu_func;
    logic       alu_fz, alu_fc;
    logic [7:0] pc, acc;
    logic       fz, fc, halted;

    logic [7:0] mem [256];
    int         wait_n;
    int         wcnt;
    int         cyc = 0;
    int         last_ack;
    int         tests = 0;
    int         fails = 0;
    txn_t       obs[$];
    txn_t       exp_q[$];

    always #5 clk = ~clk;

    exec_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .run_i        (run),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .mem_ack_i    (mem_ack),
        .alu_a_imm_o  (alu_a_imm),
        .alu_a_mem_o  (alu_a_mem),
        .alu_b_o      (alu_b),
        .alu_func_o   (alu_func),
        .alu_result_i (alu_res),
        .alu_fz_i     (alu_fz),
        .alu_fc_i     (alu_fc),
        .pc_o         (pc),
        .acc_o        (acc),
        .fz_o         (fz),
        .fc_o         (fc),
        .halted_o     (halted)
    );

    logic [7:0] alu_a;
    logic [8:0] alu_s;
    always_comb begin
        alu_a = alu_func == OP_ADI[2:0] ? alu_a_imm : alu_a_mem;
        alu_s = '0;
        case (alu_func)
            3'd0, 3'd1: alu_s = {1'b0, alu_b} + {1'b0, alu_a};
            3'd2:       alu_s = {1'b0, alu_b} - {1'b0, alu_a};
            3'd3:       alu_s = {1'b0, alu_b & alu_a};
            3'd4:       alu_s = {1'b0, alu_b | alu_a};
            3'd5:       alu_s = {1'b0, alu_b ^ alu_a};
            3'd6:       alu_s = {1'b0, alu_a << 1};
            default:    alu_s = {1'b0, alu_a >> 1};
        endcase
        alu_res = alu_s[7:0];
        alu_fc  = alu_s[8];
        alu_fz  = alu_s[7:0] == 8'h00;
    end

    assign mem_ack   = mem_req && (wcnt >= wait_n);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (mem_req && mem_ack) wcnt <= 0;
        else if (mem_req) wcnt <= wcnt + 1;
    end

    function automatic txn_t mk(input int g, input logic w, input logic [7:0] a, input logic [7:0] d,
                                input logic [7:0] c, input logic z, input logic k);
        mk.gap   = 8'(g);
        mk.we    = {3'b000, w};
        mk.addr  = a;
        mk.wdata = d;
        mk.acc   = c;
        mk.fz    = {3'b000, z};
        mk.fc    = {3'b000, k};
    endfunction

    always @(negedge clk) begin
        if (mem_req && mem_ack) begin
            obs.push_back(mk(cyc - last_ack, mem_we, mem_addr, mem_we ? mem_wdata : 8'h00, acc, fz, fc));
            last_ack = cyc;
        end
    end

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = 8'h00;
    endtask

    task automatic put(input logic [7:0] a, input logic [7:0] d);
        mem[a] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        obs.delete();
        exp_q.delete();
        rst = 1'b0;
        last_ack = cyc;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = obs.size() >= n;
        end
    endtask

    task automatic test_reset();
        bit ok;
        clear_mem();
        put(8'h00, 8'h00); put(8'h01, 8'h05); put(8'h02, 8'h80); put(8'h03, 8'h40); put(8'h40, 8'h11);
        wait_n = 3;
        run = 1'b1;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = mem_req && mem_addr == 8'h40;
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL reset_reach_oper got req=%b addr=%h want req=1 addr=40", mem_req, mem_addr); end
        tests++;
        if (acc !== 8'h05) begin fails++; $display("FAIL reset_pre_acc got %h want 05", acc); end
        rst = 1'b1;
        #1;
        tests++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, halted} !== 19'd0)
            begin fails++; $display("FAIL reset_mem_out got req=%b we=%b addr=%h wd=%h halt=%b want all 0", mem_req, mem_we, mem_addr, mem_wdata, halted); end
        tests++;
        if ({pc, acc, fz, fc} !== {RESET_PC_DEF, 8'h00, 2'b00})
            begin fails++; $display("FAIL reset_regs got pc=%h acc=%h fz=%b fc=%b want pc=00 acc=00 fz=0 fc=0", pc, acc, fz, fc); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({pc, acc, fz, fc, mem_req} !== {RESET_PC_DEF, 8'h00, 3'b000})
            begin fails++; $display("FAIL reset_release got pc=%h acc=%h fz=%b fc=%b req=%b want 00 00 0 0 0", pc, acc, fz, fc, mem_req); end
    endtask

    task automatic test_adi();
        bit ok;
        txn_t o, e;
        clear_mem();
        put(8'h00, 8'h00); put(8'h01, 8'h05); put(8'h02, 8'h00); put(8'h03, 8'hFB); put(8'h04, 8'hF0);
        wait_n = 0;
        do_reset();
        exp_q.push_back(mk(1, 0, 8'h00, 8'h00, 8'h00, 0, 0));
        exp_q.push_back(mk(1, 0, 8'h01, 8'h00, 8'h00, 0, 0));
        exp_q.push_back(mk(2, 0, 8'h02, 8'h00, 8'h05, 0, 0));
        exp_q.push_back(mk(1, 0, 8'h03, 8'h00, 8'h05, 0, 0));
        exp_q.push_back(mk(2, 0, 8'h04, 8'h00, 8'h00, 1, 1));
        exp_q.push_back(mk(1, 0, 8'h05, 8'h00, 8'h00, 1, 1));
        wait_obs(6, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL adi_count got %0d txns want 6", obs.size()); end
        while (exp_q.size() > 0 && obs.size() > 0) begin
            o = obs.pop_front();
            e = exp_q.pop_front();
            tests++;
            if (o !== e) begin fails++; $display("FAIL adi_txn got %h want %h", o, e); end
        end
        @(negedge clk);
        tests++;
        if ({pc, halted} !== {8'h06, 1'b1}) begin fails++; $display("FAIL adi_end got pc=%h halt=%b want pc=06 halt=1", pc, halted); end
    endtask

    task automatic test_lda_lsr();
        bit   fresh;
        logic [7:0] held;
        txn_t o, e;
        clear_mem();
        put(8'h00, 8'h80); put(8'h01, 8'h40); put(8'h02, 8'h70); put(8'h03, 8'h40); put(8'h04, 8'hF0);
        put(8'h40, 8'h81);
        wait_n = 2;
        do_reset();
        exp_q.push_back(mk(3, 0, 8'h00, 8'h00, 8'h00, 0, 0));
        exp_q.push_back(mk(3, 0, 8'h01, 8'h00, 8'h00, 0, 0));
        exp_q.push_back(mk(3, 0, 8'h40, 8'h00, 8'h00, 0, 0));
        exp_q.push_back(mk(4, 0, 8'h02, 8'h00, 8'h81, 0, 0));
        exp_q.push_back(mk(3, 0, 8'h03, 8'h00, 8'h81, 0, 0));
        exp_q.push_back(mk(3, 0, 8'h40, 8'h00, 8'h81, 0, 0));
        exp_q.push_back(mk(4, 0, 8'h04, 8'h00, 8'h40, 0, 0));
        exp_q.push_back(mk(3, 0, 8'h05, 8'h00, 8'h40, 0, 0));
        fresh = 1'b1;
        held  = 8'h00;
        for (int i = 0; i < 400 && obs.size() < 8; i++) begin
            @(negedge clk);
            #1;
            if (mem_req) begin
                if (!fresh) begin
                    tests++;
                    if (mem_addr !== held) begin fails++; $display("FAIL lsr_addr_hold got %h want %h", mem_addr, held); end
                end else held = mem_addr;
                fresh = mem_ack;
            end else fresh = 1'b1;
        end
        tests++;
        if (obs.size() < 8) begin fails++; $display("FAIL lsr_count got %0d txns want 8", obs.size()); end
        while (exp_q.size() > 0 && obs.size() > 0) begin
            o = obs.pop_front();
            e = exp_q.pop_front();
            tests++;
            if (o !== e) begin fails++; $display("FAIL lsr_txn got %h want %h", o, e); end
        end
    endtask

    task automatic test_sta();
        bit   ok;
        int   wr;
        txn_t o, e;
        clear_mem();
        put(8'h00, 8'h00); put(8'h01, 8'hFF); put(8'h02, 8'h00); put(8'h03, 8'h3D);
        put(8'h04, 8'h90); put(8'h05, 8'h50); put(8'h06, 8'hF0);
        wait_n = 1;
        do_reset();
        exp_q.push_back(mk(2, 0, 8'h00, 8'h00, 8'h00, 0, 0));
        exp_q.push_back(mk(2, 0, 8'h01, 8'h00, 8'h00, 0, 0));
        exp_q.push_back(mk(3, 0, 8'h02, 8'h00, 8'hFF, 0, 0));
        exp_q.push_back(mk(2, 0, 8'h03, 8'h00, 8'hFF, 0, 0));
        exp_q.push_back(mk(3, 0, 8'h04, 8'h00, 8'h3C, 0, 1));
        exp_q.push_back(mk(2, 0, 8'h05, 8'h00, 8'h3C, 0, 1));
        exp_q.push_back(mk(2, 1, 8'h50, 8'h3C, 8'h3C, 0, 1));
        exp_q.push_back(mk(3, 0, 8'h06, 8'h00, 8'h3C, 0, 1));
        exp_q.push_back(mk(2, 0, 8'h07, 8'h00, 8'h3C, 0, 1));
        wait_obs(9, ok);
        repeat (5) @(negedge clk);
        #1;
        tests++;
        if (obs.size() != 9) begin fails++; $display("FAIL sta_count got %0d txns want 9", obs.size()); end
        wr = 0;
        while (exp_q.size() > 0 && obs.size() > 0) begin
            o = obs.pop_front();
            e = exp_q.pop_front();
            if (o.we[0]) wr++;
            tests++;
            if (o !== e) begin fails++; $display("FAIL sta_txn got %h want %h", o, e); end
        end
        tests++;
        if (wr != 1) begin fails++; $display("FAIL sta_writes got %0d want 1", wr); end
        tests++;
        if ({acc, fz, fc} !== {8'h3C, 2'b01}) begin fails++; $display("FAIL sta_flags got acc=%h fz=%b fc=%b want 3C 0 1", acc, fz, fc); end
    endtask

    task automatic test_branch();
        bit   ok;
        txn_t o, e;
        clear_mem();
        put(8'h00, 8'hD0); put(8'h01, 8'hF0); put(8'h02, 8'hB0); put(8'h03, 8'h10);
        put(8'h04, 8'h00); put(8'h05, 8'h00); put(8'h06, 8'hB0); put(8'h07, 8'h10);
        put(8'h10, 8'hA0); put(8'h11, 8'hFF); put(8'hFF, 8'h00);
        wait_n = 0;
        do_reset();
        exp_q.push_back(mk(1, 0, 8'h00, 8'h00, 8'h00, 0, 0));
        exp_q.push_back(mk(1, 0, 8'h01, 8'h00, 8'h00, 0, 0));
        exp_q.push_back(mk(2, 0, 8'h02, 8'h00, 8'h00, 0, 0));
        exp_q.push_back(mk(1, 0, 8'h03, 8'h00, 8'h00, 0, 0));
        exp_q.push_back(mk(2, 0, 8'h04, 8'h00, 8'h00, 0, 0));
        exp_q.push_back(mk(1, 0, 8'h05, 8'h00, 8'h00, 0, 0));
        exp_q.push_back(mk(2, 0, 8'h06, 8'h00, 8'h00, 1, 0));
        exp_q.push_back(mk(1, 0, 8'h07, 8'h00, 8'h00, 1, 0));
        exp_q.push_back(mk(2, 0, 8'h10, 8'h00, 8'h00, 1, 0));
        exp_q.push_back(mk(1, 0, 8'h11, 8'h00, 8'h00, 1, 0));
        exp_q.push_back(mk(2, 0, 8'hFF, 8'h00, 8'h00, 1, 0));
        exp_q.push_back(mk(1, 0, 8'h00, 8'h00, 8'h00, 1, 0));
        exp_q.push_back(mk(2, 0, 8'h01, 8'h00, 8'hD0, 0, 0));
        exp_q.push_back(mk(1, 0, 8'h02, 8'h00, 8'hD0, 0, 0));
        wait_obs(14, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL branch_count got %0d txns want 14", obs.size()); end
        while (exp_q.size() > 0 && obs.size() > 0) begin
            o = obs.pop_front();
            e = exp_q.pop_front();
            tests++;
            if (o !== e) begin fails++; $display("FAIL branch_txn got %h want %h", o, e); end
        end
        @(negedge clk);
        tests++;
        if ({pc, halted} !== {8'h03, 1'b1}) begin fails++; $display("FAIL branch_end got pc=%h halt=%b want pc=03 halt=1", pc, halted); end
    endtask

    task automatic test_halt();
        bit ok;
        int reqs;
        obs.delete();
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            run = ~run;
            #1;
            if (mem_req) reqs++;
        end
        tests++;
        if (reqs != 0 || obs.size() != 0 || halted !== 1'b1)
            begin fails++; $display("FAIL halt_idle got reqs=%0d txns=%0d halt=%b want 0 0 1", reqs, obs.size(), halted); end
        run = 1'b1;
        rst = 1'b1;
        #1;
        tests++;
        if ({halted, mem_req, pc} !== {2'b00, RESET_PC_DEF}) begin fails++; $display("FAIL halt_reset got halt=%b req=%b pc=%h want 0 0 00", halted, mem_req, pc); end
        @(negedge clk);
        obs.delete();
        rst = 1'b0;
        last_ack = cyc;
        wait_obs(1, ok);
        tests++;
        if (!ok || obs[0] !== mk(1, 0, 8'h00, 8'h00, 8'h00, 0, 0))
            begin fails++; $display("FAIL halt_restart got ok=%b txn=%h want first fetch at 00", ok, ok ? obs[0] : '0); end
    endtask

    task automatic test_run_drop();
        bit ok;
        clear_mem();
        put(8'h00, 8'h00); put(8'h01, 8'h05); put(8'h02, 8'h00); put(8'h03, 8'h05); put(8'h04, 8'hF0);
        wait_n = 0;
        run = 1'b1;
        do_reset();
        wait_obs(1, ok);
        run = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        tests++;
        if (obs.size() != 2 || {acc, pc, mem_req} !== {8'h05, 8'h02, 1'b0})
            begin fails++; $display("FAIL run_drop got txns=%0d acc=%h pc=%h req=%b want 2 05 02 0", obs.size(), acc, pc, mem_req); end
        run = 1'b1;
        wait_obs(3, ok);
        tests++;
        if (!ok || obs[2].addr !== 8'h02) begin fails++; $display("FAIL run_resume got ok=%b addr=%h want 02", ok, ok ? obs[2].addr : 8'h00); end
    endtask

    initial begin
        rst    = 1'b0;
        run    = 1'b1;
        wait_n = 0;
        last_ack = 0;
        clear_mem();
        #1 rst = 1'b1;
        test_reset();
        test_adi();
        test_lda_lsr();
        test_sta();
        test_branch();
        test_halt();
        test_run_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
- Multi-cycle fetch/decode/execute sequencer that sits directly upstream of the 8-op ALU.
- Fetches two-byte instructions from a byte-wide memory and fetches the memory operand when the op needs one.
- Drives the ALU's operand and function inputs, then writes the ALU result and zero/carry flags back into the accumulator and flag registers.
- Also executes load/store/branch/halt instructions, which do not use the ALU.

Parameters:
- RESET_PC, 8'h00, program counter value loaded on reset.
- WORD_W, 8, data/address width; the ALU interface is fixed at 8, so only 8 is supported.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- run_i  in  1  level; while 0, FSM holds in FETCH0 without issuing requests.
- mem_req_o  out  1  memory request; held until ack.
- mem_we_o  out  1  1 = write, 0 = read; valid with req.
- mem_addr_o  out  8  byte address.
- mem_wdata_o  out  8  store data (acc).
- mem_rdata_i  in  8  read data; valid in the ack cycle.
- mem_ack_i  in  1  access complete; sampled only while req=1.
- alu_a_imm_o  out  8  immediate operand (instruction byte1).
- alu_a_mem_o  out  8  memory operand register.
- alu_b_o  out  8  accumulator.
- alu_func_o  out  3  ALU function (opcode[2:0]).
- alu_result_i  in  8  ALU result.
- alu_fz_i  in  1  ALU zero flag.
- alu_fc_i  in  1  ALU carry flag.
- pc_o  out  8  program counter.
- acc_o  out  8  accumulator.
- fz_o  out  1  registered zero flag.
- fc_o  out  1  registered carry flag.
- halted_o  out  1  1 while in HALT.

Behaviour:
- Reset (async, immediate):
  - state=FETCH0, pc=RESET_PC, acc=0, fz=0, fc=0, ir0=ir1=opnd=0.
  - All mem outputs and halted_o go 0 immediately; any in-flight access is abandoned.
- Instruction format:
  - byte0 = {op[3:0], 4'b0}; byte1 = imm8 or addr8.
  - op 0xxx: ALU op, func = op[2:0]; func 000 (ADI) uses imm, all others use mem[addr].
  - 1000 LDA, 1001 STA, 1010 JMP, 1011 JZ, 1100 JC, 1101/1110 NOP, 1111 HLT.
- Memory handshake:
  - req, we, addr (and wdata for a write) are held stable from assertion until the cycle ack=1 inclusive.
  - Ack may arrive in the same cycle req first rises, which gives a 1-cycle access.
  - req deasserts (or re-targets) the cycle after ack.
  - Unsolicited ack is ignored.
- States:
  - FETCH0: if run_i=1, read mem[pc]. On ack: ir0=rdata, pc=pc+1 → FETCH1.
  - FETCH1: read mem[pc]. On ack: ir1=rdata, pc=pc+1. Then:
    - ADI, JMP, JZ, JC, NOP → EXEC
    - other ALU ops, LDA → OPER
    - STA → STORE
    - HLT → HALT
  - OPER: read mem[ir1]. On ack: opnd=rdata → EXEC.
  - EXEC (1 cycle, no memory):
    - ALU op: acc=alu_result_i, fz=alu_fz_i, fc=alu_fc_i.
    - LDA: acc=opnd, fz=(opnd==0), fc unchanged.
    - JMP: pc=ir1.
    - JZ: pc=ir1 if fz. JC: pc=ir1 if fc.
    - NOP: nothing.
    - Then → FETCH0.
  - STORE: write mem[ir1]=acc. On ack → FETCH0. Flags unchanged.
  - HALT: halted_o=1, no requests; exit only by reset.
- ALU drive: alu_a_imm_o=ir1, alu_a_mem_o=opnd, alu_b_o=acc, alu_func_o=ir0[6:4], all driven continuously. The result is captured only in EXEC.
- Latency with zero-wait memory (ack in the req cycle):
  - ADI, JMP, JZ, JC, NOP: 3 cycles.
  - mem-ALU, LDA, STA: 4 cycles.
  - Each memory wait cycle adds 1.
- Boundaries:
  - pc wraps 8'hFF→8'h00, so an instruction at 0xFF takes byte1 from 0x00.
  - A branch target equal to the current pc is legal.
  - run_i dropping mid-instruction takes effect only at the next FETCH0; the current instruction completes.
  - The flag used by JZ/JC is the value registered before that instruction.
  - Logical/shift ops write fc from the ALU (0).

Decomposition:
- Shared package holds:
  - state encoding (FETCH0, FETCH1, OPER, EXEC, STORE, HALT);
  - opcode constants (OP_ADI..OP_LSR, OP_LDA, OP_STA, OP_JMP, OP_JZ, OP_JC, OP_HLT);
  - RESET_PC default.
- One natural sub-module: op_decode, combinational, ir0 → needs_mem, is_alu, is_store, is_branch, is_halt, func.
- Registers and FSM stay in exec_ctrl; the ALU is instantiated beside it at top level, not inside.

Test Plan:
- Reset: assert rst_i mid-OPER with req=1 → req drops same cycle; after release pc=00, acc=00, fz=fc=0.
- ADI 0x05 then ADI 0xFB, zero-wait memory → acc 05 then 00, fz=1, fc=1; each instruction 3 cycles.
- mem[0x40]=0x81, LDA 0x40; LSR 0x40 with 2-cycle ack delay → acc=81 then 40; OPER holds addr 40 stable across the wait.
- STA 0x50 with acc=0x3C → one write, we=1, addr=50, wdata=3C, held until ack; fz/fc unchanged.
- JZ 0x10 with fz=0, then with fz=1 → pc=next sequential, then pc=10. Program at 0xFF: byte1 fetched from 0x00.
- HLT → halted_o=1, no mem_req for 20 cycles; run_i toggling has no effect; rst_i restarts at RESET_PC.
